pad_in_filter: RTL and testbench

- Per-pad input conditioning stage directly downstream of the pad frame. Consumes the raw in_* pad outputs, which are asynchronous to the SoC clock.
- For each pad: two-flop synchronisation, an optional programmable glitch filter, rise/fall edge detection, and sticky edge-interrupt status.
- Outputs feed the peripheral pad mux, the GPIO block and the event unit.

---
 rtl/pad_in_filter.sv | 80 ++++++++
 tb/tb_pad_in_filter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pad_in_filter.sv
// Per-pad input conditioning: 2-flop sync, glitch filter, edge detect, sticky irq status.
// Latency: pad_filt_o at edge 3 (bypass) or L+3 (filtered); no backpressure, accepts every cycle.
module pad_in_filter #(
  parameter int                    NUM_PADS  = 32,
  parameter int                    CNT_W     = 8,
  parameter logic [NUM_PADS-1:0]   RESET_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_PADS-1:0] pad_in_i,
  input  logic [NUM_PADS-1:0] filt_en_i,
  input  logic [CNT_W-1:0]    filt_len_i,
  input  logic [NUM_PADS-1:0] irq_rise_en_i,
  input  logic [NUM_PADS-1:0] irq_fall_en_i,
  input  logic [NUM_PADS-1:0] irq_clr_i,
  output logic [NUM_PADS-1:0] pad_filt_o,
  output logic [NUM_PADS-1:0] rise_o,
  output logic [NUM_PADS-1:0] fall_o,
  output logic [NUM_PADS-1:0] irq_status_o,
  output logic                irq_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_PADS-1:0] s1_q, s2_q;
  logic [NUM_PADS-1:0] filt_q, filt_d;
  logic [NUM_PADS-1:0] rise_q, fall_q;
  logic [NUM_PADS-1:0] stat_q;
  logic [CNT_W-1:0]    cnt_q [NUM_PADS];
  logic [CNT_W-1:0]    cnt_d [NUM_PADS];

  // A pad value is accepted once s2 has disagreed with it for L+1 consecutive samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NUM_PADS; i++) begin
      cnt_d[i] = '0;
      if (!filt_en_i[i]) begin
        filt_d[i] = s2_q[i];
      end else if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] >= filt_len_i) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= RESET_VAL;
      s2_q   <= RESET_VAL;
      filt_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      stat_q <= '0;
      for (int i = 0; i < NUM_PADS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= pad_in_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
      // Status is fed by the registered pulses, so a set lands one edge after the pulse.
      stat_q <= (stat_q & ~irq_clr_i) | (rise_q & irq_rise_en_i) | (fall_q & irq_fall_en_i);
      for (int i = 0; i < NUM_PADS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pad_filt_o   = filt_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign irq_status_o = stat_q;
  assign irq_o        = |stat_q;

endmodule

// File: tb/tb_pad_in_filter.sv
// Randomized and directed bench for pad_in_filter against a per-pad behavioural model.
// Model: a pad value is adopted after L+1 consecutive disagreeing synchronised samples.
module tb_pad_in_filter;

  localparam int          N  = 32;
  localparam logic [31:0] RV = 32'h0000_0080;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pad_in, filt_en, irq_rise_en, irq_fall_en, irq_clr;
  logic [7:0]    filt_len;
  logic [31:0]   pad_filt, rise, fall, irq_status;
  logic          irq;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  pad_in_filter #(.NUM_PADS(N), .CNT_W(8), .RESET_VAL(RV)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pad_in_i      (pad_in),
    .filt_en_i     (filt_en),
    .filt_len_i    (filt_len),
    .irq_rise_en_i (irq_rise_en),
    .irq_fall_en_i (irq_fall_en),
    .irq_clr_i     (irq_clr),
    .pad_filt_o    (pad_filt),
    .rise_o        (rise),
    .fall_o        (fall),
    .irq_status_o  (irq_status),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: pipeline of sampled values plus a per-pad run length of disagreement.
  bit [31:0] m_s1, m_s2, m_filt, m_nf, m_rise, m_fall, m_stat;
  int        m_run [N];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = RV; m_s2 = RV; m_filt = RV;
      m_rise = '0; m_fall = '0; m_stat = '0;
      for (int p = 0; p < N; p++) m_run[p] = 0;
    end else begin
      m_stat = (m_stat & ~irq_clr) | (m_rise & irq_rise_en) | (m_fall & irq_fall_en);
      m_nf = m_filt;
      for (int p = 0; p < N; p++) begin
        if (!filt_en[p]) begin
          m_nf[p] = m_s2[p];
          m_run[p] = 0;
        end else if (m_s2[p] == m_filt[p]) begin
          m_run[p] = 0;
        end else begin
          m_run[p] = m_run[p] + 1;
          if (m_run[p] > int'(filt_len)) begin
            m_nf[p] = m_s2[p];
            m_run[p] = 0;
          end
        end
      end
      m_rise = m_nf & ~m_filt;
      m_fall = ~m_nf & m_filt;
      m_filt = m_nf;
      m_s2 = m_s1;
      m_s1 = pad_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pad_filt", pad_filt, m_filt);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_status", irq_status, m_stat);
      check("model_irq", {31'd0, irq}, {31'd0, (m_stat != 0)});
      check("rise_and_fall_exclusive", rise & fall, 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; pad_in = '0; filt_en = '0; filt_len = 8'd0;
    irq_rise_en = '0; irq_fall_en = '0; irq_clr = '0;
    tick(2);
    chk_en = 1'b1;
    check("reset_pad_filt", pad_filt, RV);
    check("reset_rise", rise, 32'd0);
    check("reset_status", irq_status, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;

    // Bypass latency on pad 0.
    pad_in[0] = 1'b1;
    tick(2);
    check("byp_edge2_filt0", {31'd0, pad_filt[0]}, 32'd0);
    tick();
    check("byp_edge3_filt0", {31'd0, pad_filt[0]}, 32'd1);
    check("byp_edge3_rise0", {31'd0, rise[0]}, 32'd1);
    tick();
    check("byp_edge4_rise0", {31'd0, rise[0]}, 32'd0);
    check("byp_status", irq_status, 32'd0);

    // Glitch filter on pad 5 with L=4.
    filt_en[5] = 1'b1; filt_len = 8'd4;
    pad_in[5] = 1'b1;
    tick(4);
    pad_in[5] = 1'b0;
    tick(12);
    check("glitch4_rejected", {31'd0, pad_filt[5]}, 32'd0);
    pad_in[5] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5) pad_in[5] = 1'b0;
      if (e == 6) check("pulse5_edge6", {31'd0, pad_filt[5]}, 32'd0);
      if (e == 7) begin
        check("pulse5_edge7", {31'd0, pad_filt[5]}, 32'd1);
        check("pulse5_rise", {31'd0, rise[5]}, 32'd1);
      end
      if (e == 11) check("pulse5_edge11", {31'd0, pad_filt[5]}, 32'd1);
      if (e == 12) begin
        check("pulse5_edge12", {31'd0, pad_filt[5]}, 32'd0);
        check("pulse5_fall", {31'd0, fall[5]}, 32'd1);
      end
    end

    // Sticky status on pad 3, set-wins over clear, then lone clear.
    irq_rise_en[3] = 1'b1;
    pad_in[3] = 1'b1;
    tick(3);
    check("irq_rise3", {31'd0, rise[3]}, 32'd1);
    check("irq_status_before", irq_status, 32'd0);
    tick();
    check("irq_status3_set", irq_status, 32'h0000_0008);
    check("irq_o_set", {31'd0, irq}, 32'd1);
    pad_in[3] = 1'b0;
    tick(5);
    pad_in[3] = 1'b1;
    tick(3);
    irq_clr[3] = 1'b1;
    tick();
    irq_clr[3] = 1'b0;
    check("irq_set_wins", irq_status, 32'h0000_0008);
    irq_clr[3] = 1'b1;
    tick();
    irq_clr[3] = 1'b0;
    check("irq_cleared", irq_status, 32'd0);
    check("irq_o_cleared", {31'd0, irq}, 32'd0);

    // Shortening L mid-count on pad 9.
    filt_en[9] = 1'b1; filt_len = 8'd10;
    pad_in[9] = 1'b1;
    tick(8);
    check("len_mid_hold", {31'd0, pad_filt[9]}, 32'd0);
    filt_len = 8'd3;
    tick();
    check("len_shorten_update", {31'd0, pad_filt[9]}, 32'd1);

    // Disabling the filter mid-count on pad 10.
    filt_len = 8'd10; filt_en[10] = 1'b1;
    pad_in[10] = 1'b1;
    tick(6);
    check("dis_mid_hold", {31'd0, pad_filt[10]}, 32'd0);
    filt_en[10] = 1'b0;
    tick();
    check("dis_pass", {31'd0, pad_filt[10]}, 32'd1);

    // All pads, random toggles, mixed enables and lengths.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) filt_en = $urandom;
      if ($urandom_range(0, 99) < 2) filt_len = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 2) begin
        irq_rise_en = $urandom; irq_fall_en = $urandom;
      end
      irq_clr = ($urandom_range(0, 9) == 0) ? $urandom : 32'd0;
      case ($urandom_range(0, 15))
        0:       pad_in = ~pad_in;
        1, 2:    pad_in = pad_in ^ $urandom;
        3:       pad_in = pad_in ^ ($urandom & $urandom);
        default: ;
      endcase
      tick();
    end
    irq_clr = '0;

    // Reset mid-count on pad 7 while status is pending.
    irq_rise_en = '1; irq_fall_en = '1; filt_en = '0; pad_in = '0;
    tick(5);
    pad_in[7] = 1'b1;
    tick(5);
    check("pre_rst_filt7", {31'd0, pad_filt[7]}, 32'd1);
    filt_en[7] = 1'b1; filt_len = 8'd10;
    pad_in[7] = 1'b0;
    tick(6);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    check("pre_rst_hold7", {31'd0, pad_filt[7]}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_pad_filt", pad_filt, RV);
    check("rst_rise", rise, 32'd0);
    check("rst_fall", fall, 32'd0);
    check("rst_status", irq_status, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    tick();
    check("post_rst_rise", rise, 32'd0);
    check("post_rst_fall", fall, 32'd0);
    check("post_rst_status", irq_status, 32'd0);
    tick(20);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
